// File: rtl/edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// edge_event_arbiter
//
// Purpose:
//   Watches NUM_CH synchronous status lines for rising and/or falling edges,
//   latches every detected edge as a pending event (one slot per channel and
//   edge direction), and presents pending events one at a time on a
//   valid/ready port. A round-robin pointer picks which pending slot is served
//   next. An edge that arrives while its slot is still pending is lost and
//   flagged in a sticky per-channel overflow bit.
//
//   Slot numbering: slot s = 2*ch + (falling ? 1 : 0), 2*NUM_CH slots total.
//
// Optional feature (macro EDGE_TIMESTAMP_EN):
//   Adds a free-running 16-bit cycle counter. Each slot records the counter
//   value when its pending bit goes from clear to set, and the stamp of the
//   granted slot is presented on event_ts alongside event_ch.
//
// Ports:
//   clock         in   system clock, all logic on posedge
//   reset         in   synchronous active-high reset
//   data          in   [NUM_CH]  monitored lines (already synchronous)
//   cfg_rise_en   in   [NUM_CH]  per-channel rising-edge detect enable
//   cfg_fall_en   in   [NUM_CH]  per-channel falling-edge detect enable
//   event_valid   out  event presented
//   event_ready   in   consumer accepts the event when high with event_valid
//   event_ch      out  [IDX_W]   channel of presented event
//   event_rise    out  1 = rising edge event, 0 = falling edge event
//   overflow      out  [NUM_CH]  sticky lost-edge flags
//   clr_overflow  in   [NUM_CH]  per-channel clear pulse for overflow
//   event_ts      out  [16]      stamp of presented event (EDGE_TIMESTAMP_EN)
// -----------------------------------------------------------------------------
module edge_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] data,
  input  logic [NUM_CH-1:0] cfg_rise_en,
  input  logic [NUM_CH-1:0] cfg_fall_en,
  output logic              event_valid,
  input  logic              event_ready,
  output logic [IDX_W-1:0]  event_ch,
  output logic              event_rise,
  output logic [NUM_CH-1:0] overflow,
`ifdef EDGE_TIMESTAMP_EN
  output logic [15:0]       event_ts,
`endif
  input  logic [NUM_CH-1:0] clr_overflow
);

  localparam int NS     = 2 * NUM_CH;
  localparam int SLOT_W = IDX_W + 1;

  typedef enum logic {IDLE, PRESENT} state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   prev_q;
  logic [NS-1:0]       pend_q, pend_d;
  logic [NUM_CH-1:0]   ovf_q, ovf_d;
  logic [SLOT_W-1:0]   ptr_q, ptr_d;
  logic [SLOT_W-1:0]   grant_q, grant_d;
  logic                valid_q, valid_d;
  logic [IDX_W-1:0]    ch_q, ch_d;
  logic                rise_q, rise_d;

  logic [NS-1:0]       edge_vec;
  logic [NS-1:0]       clr_vec;
  logic [NS-1:0]       lost_vec;
  logic [NUM_CH-1:0]   ovf_set;
  logic [SLOT_W:0]     pick;
  logic                pick_found;
  logic [SLOT_W-1:0]   pick_slot_idx;

  // First set request at or above ptr, wrapping. MSB of result = found.
  function automatic logic [SLOT_W:0] pick_slot(input logic [NS-1:0]     req,
                                                input logic [SLOT_W-1:0] ptr);
    logic [SLOT_W:0] res;
    int              idx;
    res = '0;
    for (int k = 0; k < NS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NS) idx = idx - NS;
      if (!res[SLOT_W] && req[idx]) res = {1'b1, idx[SLOT_W-1:0]};
    end
    return res;
  endfunction

  // Edge detection, slot-ordered
  always_comb begin
    edge_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      edge_vec[2*i]   = data[i] & ~prev_q[i] & cfg_rise_en[i];
      edge_vec[2*i+1] = ~data[i] & prev_q[i] & cfg_fall_en[i];
    end
  end

  assign pick          = pick_slot(pend_q, ptr_q);
  assign pick_found    = pick[SLOT_W];
  assign pick_slot_idx = pick[SLOT_W-1:0];

  // Grant / present FSM
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    valid_d = valid_q;
    ch_d    = ch_q;
    rise_d  = rise_q;
    clr_vec = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_slot_idx;
          ch_d    = pick_slot_idx[SLOT_W-1:1];
          rise_d  = ~pick_slot_idx[0];
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (event_ready) begin
          clr_vec = NS'(1) << grant_q;
          ptr_d   = (grant_q == SLOT_W'(NS - 1)) ? '0 : grant_q + SLOT_W'(1);
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new edge on the slot being acknowledged re-arms it instead of overflowing.
  always_comb begin
    lost_vec = edge_vec & pend_q & ~clr_vec;
    pend_d   = (pend_q & ~clr_vec) | edge_vec;
    ovf_set  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ovf_set[i] = lost_vec[2*i] | lost_vec[2*i+1];
    end
    // Set has priority over clear.
    ovf_d = (ovf_q & ~clr_overflow) | ovf_set;
  end

  // prev tracks data even during reset so a line held high causes no edge.
  always_ff @(posedge clock) begin
    prev_q <= data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ovf_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      rise_q  <= rise_d;
    end
  end

  assign event_valid = valid_q;
  assign event_ch    = ch_q;
  assign event_rise  = rise_q;
  assign overflow    = ovf_q;

`ifdef EDGE_TIMESTAMP_EN
  logic [15:0]   ts_cnt_q;
  logic [15:0]   ts_q;
  logic [15:0]   stamp_q [NS];
  logic [NS-1:0] new_set;

  // Only a clear-to-set transition takes a stamp; lost edges leave it alone.
  assign new_set = edge_vec & (~pend_q | clr_vec);

  always_ff @(posedge clock) begin
    for (int s = 0; s < NS; s++) begin
      if (new_set[s]) stamp_q[s] <= ts_cnt_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 16'd1;
      if (state_q == IDLE && pick_found) ts_q <= stamp_q[pick_slot_idx];
    end
  end

  assign event_ts = ts_q;
`endif

endmodule
